// File: rtl/busreg_pkg.sv
// Shared encodings for the bus register file: command opcodes, FSM states and SWAP phases.
package busreg_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] PH_TEMP = 2'd0;
  localparam logic [1:0] PH_SRC  = 2'd1;
  localparam logic [1:0] PH_DST  = 2'd2;

endpackage

// File: rtl/busreg_cell.sv
// One WIDTH-bit storage register with load enable and async active-low reset.
module busreg_cell
  import busreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/bus_regfile.sv
// NUM_REGS x WIDTH register file sharing one muxed internal bus, driven by a cmd/rsp FSM.
// Define BUSREG_SWAP_EN to add the 3-transfer SWAP through a hidden temp register.
module bus_regfile
  import busreg_pkg::*;
#(
  parameter  int NUM_REGS = 4,
  parameter  int WIDTH    = 8,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_src,
  input  logic [IDX_W-1:0] cmd_dst,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] bus,
  output logic             bus_valid
);

  state_t                         st, st_nxt;
  logic [1:0]                     op_q;
  logic [IDX_W-1:0]               src_q, dst_q;
  logic [WIDTH-1:0]               data_q, first_q, src_val, bus_val;
  logic                           err_q, legal, src_ok, dst_ok, accept;
  logic                           xfer_last, first_xfer;
  logic [NUM_REGS-1:0]            reg_we, dst_oh;
  logic [NUM_REGS-1:0][WIDTH-1:0] regs;

  // Every register loads from the bus; only the enable differs.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    busreg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (reg_we[i]),
      .d   (bus_val),
      .q   (regs[i])
    );
  end

  always_comb begin
    src_val = '0;
    dst_oh  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src_q == IDX_W'(i)) src_val = regs[i];
      dst_oh[i] = (dst_q == IDX_W'(i));
    end
  end

`ifdef BUSREG_SWAP_EN
  logic [1:0]          phase_q;
  logic                tmp_we;
  logic [WIDTH-1:0]    tmp_q, dst_val;
  logic [NUM_REGS-1:0] src_oh;

  busreg_cell #(.WIDTH(WIDTH)) u_tmp (
    .clk (clk),
    .rst (rst),
    .en  (tmp_we),
    .d   (bus_val),
    .q   (tmp_q)
  );

  always_comb begin
    dst_val = '0;
    src_oh  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dst_q == IDX_W'(i)) dst_val = regs[i];
      src_oh[i] = (src_q == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             phase_q <= PH_TEMP;
    else if (accept)                      phase_q <= PH_TEMP;
    else if (st == ST_XFER && !xfer_last) phase_q <= phase_q + 2'd1;
  end
`endif

  // Only the indices an op actually uses are range-checked.
  always_comb begin
    src_ok = 32'(cmd_src) < 32'(NUM_REGS);
    dst_ok = 32'(cmd_dst) < 32'(NUM_REGS);
    legal  = 1'b0;
    case (cmd_op)
      OP_LOAD: legal = dst_ok;
      OP_MOVE: legal = src_ok && dst_ok;
      OP_READ: legal = src_ok;
      default: begin
`ifdef BUSREG_SWAP_EN
        legal = src_ok && dst_ok;
`else
        legal = 1'b0;
`endif
      end
    endcase
  end

  always_comb begin
    bus_val    = '0;
    reg_we     = '0;
    xfer_last  = 1'b1;
    first_xfer = 1'b1;
`ifdef BUSREG_SWAP_EN
    tmp_we     = 1'b0;
`endif
    if (st == ST_XFER) begin
      case (op_q)
        OP_LOAD: begin bus_val = data_q;  reg_we = dst_oh; end
        OP_MOVE: begin bus_val = src_val; reg_we = dst_oh; end
        OP_READ: bus_val = src_val;
        default: begin
`ifdef BUSREG_SWAP_EN
          first_xfer = (phase_q == PH_TEMP);
          xfer_last  = (phase_q == PH_DST);
          case (phase_q)
            PH_TEMP: begin bus_val = src_val; tmp_we = 1'b1;   end
            PH_SRC:  begin bus_val = dst_val; reg_we = src_oh; end
            default: begin bus_val = tmp_q;   reg_we = dst_oh; end
          endcase
`endif
        end
      endcase
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if (cmd_valid) st_nxt = legal ? ST_XFER : ST_RESP;
      ST_XFER: if (xfer_last) st_nxt = ST_RESP;
      default: st_nxt = ST_IDLE;
    endcase
  end

  assign cmd_ready = (st == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign bus_valid = (st == ST_XFER);
  assign bus       = bus_val;
  assign rsp_valid = (st == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_data  = (rsp_valid && !err_q) ? first_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= ST_IDLE;
      op_q    <= OP_LOAD;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      first_q <= '0;
    end else begin
      st <= st_nxt;
      if (accept) begin
        op_q   <= cmd_op;
        src_q  <= cmd_src;
        dst_q  <= cmd_dst;
        data_q <= cmd_data;
        err_q  <= !legal;
      end
      if (st == ST_XFER && first_xfer) first_q <= bus_val;
    end
  end

endmodule

// File: tb/tb_bus_regfile.sv
// Directed bench for bus_regfile: a 4-register and a 3-register instance checked against a reference model.
module tb_bus_regfile;
  import busreg_pkg::*;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         lat;
    int         nbus;
    logic [7:0] first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v4 = 1'b0, v3 = 1'b0;
  logic [1:0] op = 2'b00, src = 2'd0, dst = 2'd0;
  logic [7:0] data = 8'h00;

  logic       rdy4, rv4, re4, bv4, rdy3, rv3, re3, bv3;
  logic [7:0] rd4, b4, rd3, b3;

  int total = 0, passed = 0, fails = 0;
  exp_t q[$];
  logic [7:0] m4 [4];
  logic [7:0] m3 [3];

  always #5 clk = ~clk;

  bus_regfile #(.NUM_REGS(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(v4), .cmd_ready(rdy4), .cmd_op(op),
    .cmd_src(src), .cmd_dst(dst), .cmd_data(data), .rsp_valid(rv4),
    .rsp_err(re4), .rsp_data(rd4), .bus(b4), .bus_valid(bv4)
  );

  bus_regfile #(.NUM_REGS(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_op(op),
    .cmd_src(src), .cmd_dst(dst), .cmd_data(data), .rsp_valid(rv3),
    .rsp_err(re3), .rsp_data(rd3), .bus(b3), .bus_valid(bv3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clr_model();
    for (int i = 0; i < 4; i++) m4[i] = 8'h00;
    for (int i = 0; i < 3; i++) m3[i] = 8'h00;
  endtask

  function automatic logic [7:0] mrd(input bit sel, input logic [1:0] idx);
    return sel ? m3[idx] : m4[idx];
  endfunction

  task automatic mwr(input bit sel, input logic [1:0] idx, input logic [7:0] val);
    if (sel) m3[idx] = val;
    else     m4[idx] = val;
  endtask

  // Predict the response from the model, push it, then drive the command and
  // pop/compare when rsp_valid shows up.
  task automatic run(input bit sel, input logic [1:0] o, input logic [1:0] s,
                     input logic [1:0] d, input logic [7:0] dt, input string tag);
    exp_t e, g;
    int n, nb;
    bit bad, got;
    logic [7:0] fb, tv;
    n   = sel ? 3 : 4;
    bad = 1'b0;
    case (o)
      OP_LOAD: bad = (int'(d) >= n);
      OP_MOVE: bad = (int'(s) >= n) || (int'(d) >= n);
      OP_READ: bad = (int'(s) >= n);
      default: begin
`ifdef BUSREG_SWAP_EN
        bad = (int'(s) >= n) || (int'(d) >= n);
`else
        bad = 1'b1;
`endif
      end
    endcase
    e.err = bad; e.data = 8'h00; e.lat = 1; e.nbus = 0; e.first = 8'h00;
    if (!bad) begin
      e.lat = 2; e.nbus = 1;
      case (o)
        OP_LOAD: begin e.data = dt; mwr(sel, d, dt); end
        OP_MOVE: begin e.data = mrd(sel, s); mwr(sel, d, e.data); end
        OP_READ: e.data = mrd(sel, s);
        default: begin
          e.lat = 4; e.nbus = 3;
          e.data = mrd(sel, s);
          tv = mrd(sel, d);
          mwr(sel, s, tv);
          mwr(sel, d, e.data);
        end
      endcase
      e.first = e.data;
    end
    q.push_back(e);

    @(negedge clk);
    chk({tag, ":ready"}, sel ? rdy3 : rdy4, 1);
    op = o; src = s; dst = d; data = dt;
    if (sel) v3 = 1'b1; else v4 = 1'b1;
    got = 1'b0; nb = 0; fb = 8'h00;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      v3 = 1'b0; v4 = 1'b0;
      if (sel ? bv3 : bv4) begin
        if (nb == 0) fb = sel ? b3 : b4;
        nb++;
      end else begin
        chk({tag, ":bus_idle"}, sel ? b3 : b4, 0);
      end
      if (sel ? rv3 : rv4) begin
        got = 1'b1;
        g = q.pop_front();
        chk({tag, ":err"},  sel ? re3 : re4, g.err);
        chk({tag, ":data"}, sel ? rd3 : rd4, g.data);
        chk({tag, ":lat"},  c,  g.lat);
        chk({tag, ":nbus"}, nb, g.nbus);
        if (g.nbus > 0) chk({tag, ":first_bus"}, fb, g.first);
      end
    end
    if (!got) begin
      chk({tag, ":timeout"}, 0, 1);
      void'(q.pop_front());
    end
  endtask

  initial begin
    clr_model();
    // reset state
    repeat (2) @(negedge clk);
    chk("rst:ready", rdy4, 1);
    chk("rst:bus_valid", bv4, 0);
    chk("rst:rsp_valid", rv4, 0);
    chk("rst:bus", b4, 0);
    chk("rst:rsp_data", rd4, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) run(0, OP_READ, 2'(i), 2'd0, 8'h00, "rd_init");

    // LOAD, MOVE, READ
    run(0, OP_LOAD, 2'd0, 2'd2, 8'hA5, "ld_a5");
    run(0, OP_MOVE, 2'd2, 2'd0, 8'h00, "mv_2_0");
    run(0, OP_READ, 2'd0, 2'd0, 8'h00, "rd_r0");
    run(0, OP_READ, 2'd2, 2'd0, 8'h00, "rd_r2");

    // SWAP (or its rejection when compiled out)
    run(0, OP_LOAD, 2'd0, 2'd1, 8'h11, "ld_11");
    run(0, OP_LOAD, 2'd0, 2'd3, 8'h33, "ld_33");
    run(0, OP_SWAP, 2'd1, 2'd3, 8'h00, "swap_1_3");
    run(0, OP_READ, 2'd1, 2'd0, 8'h00, "rd_r1");
    run(0, OP_READ, 2'd3, 2'd0, 8'h00, "rd_r3");
    run(0, OP_SWAP, 2'd2, 2'd2, 8'h00, "swap_same");
    run(0, OP_READ, 2'd2, 2'd0, 8'h00, "rd_r2b");

    // MOVE onto itself
    run(0, OP_MOVE, 2'd1, 2'd1, 8'h00, "mv_same");
    run(0, OP_READ, 2'd1, 2'd0, 8'h00, "rd_r1b");

    // out-of-range indices on the 3-register instance
    run(1, OP_LOAD, 2'd0, 2'd2, 8'h7E, "n3_ld2");
    run(1, OP_LOAD, 2'd0, 2'd3, 8'hC3, "n3_ld3");
    run(1, OP_MOVE, 2'd3, 2'd2, 8'h00, "n3_mv3");
    run(1, OP_READ, 2'd3, 2'd0, 8'h00, "n3_rd3");
    run(1, OP_READ, 2'd0, 2'd3, 8'h00, "n3_rd0_dst3");
    run(1, OP_READ, 2'd2, 2'd0, 8'h00, "n3_rd2");

    // reset mid-run clears everything
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clr_model();
    chk("rst2:ready", rdy4, 1);
    chk("rst2:bus_valid", bv4, 0);
    for (int i = 0; i < 4; i++) run(0, OP_READ, 2'(i), 2'd0, 8'h00, "rd_rst2");
    run(1, OP_READ, 2'd2, 2'd0, 8'h00, "n3_rd_rst2");

    // reset during the XFER of a MOVE aborts it without a response
    run(0, OP_LOAD, 2'd0, 2'd0, 8'h5A, "ld_5a");
    @(negedge clk);
    op = OP_MOVE; src = 2'd0; dst = 2'd1; v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    chk("abort:in_xfer", bv4, 1);
    chk("abort:bus", b4, 8'h5A);
    rst = 1'b0;
    #1;
    chk("abort:bus_drop", bv4, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort:no_rsp", rv4, 0);
    end
    rst = 1'b1;
    clr_model();
    for (int i = 0; i < 4; i++) run(0, OP_READ, 2'(i), 2'd0, 8'h00, "rd_abort");
    run(0, OP_LOAD, 2'd0, 2'd1, 8'h3C, "ld_after");
    run(0, OP_MOVE, 2'd1, 2'd3, 8'h00, "mv_after");
    run(0, OP_READ, 2'd3, 2'd0, 8'h00, "rd_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
